// File: rtl/burst_code_pkg.sv
// Shared definitions for the (41,32) burst-3 code family:
// codeword and message types, code dimensions, and the serializer state type.
package burst_code_pkg;

    localparam int N         = 41;  // codeword length
    localparam int K         = 32;  // message length
    localparam int R         = 9;   // parity length
    localparam int BURST_LEN = 3;   // longest correctable burst
    localparam int CNT_W     = 6;   // bit-counter width, 2**CNT_W >= N

    typedef logic [0:N-1]       cw_t;    // {m[0:31], p[0:8]}, index 0 is sent first
    typedef logic [0:K-1]       msg_t;
    typedef logic [CNT_W-1:0]   cnt_t;
    typedef logic [BURST_LEN-1:0] burst_t;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    localparam cnt_t LAST_BIT = cnt_t'(N - 1);

endpackage

// File: rtl/burst_cw_serializer_if.sv
// Codeword-in / bit-out bus of burst_cw_serializer.
// master: upstream/downstream environment; slave: the serializer itself.
// The inj_* signals exist only when BURST_INJECT_EN is defined.
interface burst_cw_serializer_if;
    import burst_code_pkg::*;

    logic   cw_valid;
    logic   cw_ready;
    cw_t    cw;
    logic   ser_valid;
    logic   ser_ready;
    logic   ser_bit;
    logic   ser_sof;
    logic   ser_eof;
`ifdef BURST_INJECT_EN
    logic   inj_arm;
    cnt_t   inj_pos;
    burst_t inj_mask;

    modport master (
        output cw_valid, cw, ser_ready, inj_arm, inj_pos, inj_mask,
        input  cw_ready, ser_valid, ser_bit, ser_sof, ser_eof
    );

    modport slave (
        input  cw_valid, cw, ser_ready, inj_arm, inj_pos, inj_mask,
        output cw_ready, ser_valid, ser_bit, ser_sof, ser_eof
    );
`else
    modport master (
        output cw_valid, cw, ser_ready,
        input  cw_ready, ser_valid, ser_bit, ser_sof, ser_eof
    );

    modport slave (
        input  cw_valid, cw, ser_ready,
        output cw_ready, ser_valid, ser_bit, ser_sof, ser_eof
    );
`endif

endinterface

// File: rtl/burst_cw_serializer_injector.sv
// burst_injector: combinational burst-error mask generator.
// Flags the current bit for inversion when cnt lies in pos..pos+BURST_LEN-1
// and the matching mask bit is set (mask bit0 -> pos). Bits past N-1 never
// occur because the counter stops at N-1, so the burst clips naturally;
// pos >= N therefore injects nothing.
module burst_injector
    import burst_code_pkg::*;
(
    input  cnt_t   cnt,
    input  cnt_t   pos,
    input  burst_t mask,
    output logic   flip
);

    cnt_t offset;

    // Offset of the current bit inside the burst window and the selected mask bit
    always_comb begin
        offset = cnt - pos;
        flip   = 1'b0;
        if (cnt >= pos) begin
            case (offset)
                cnt_t'(0): flip = mask[0];
                cnt_t'(1): flip = mask[1];
                cnt_t'(2): flip = mask[2];
                default:   flip = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/burst_cw_serializer.sv
// burst_cw_serializer: accepts one 41-bit codeword per valid/ready handshake
// and shifts it out one bit per downstream beat, c[0] first, with sof/eof
// flags and backpressure. The last beat of a frame may coincide with the next
// accept, giving gap-free back-to-back frames.
// Optional macro BURST_INJECT_EN adds a per-frame burst-error injector
// (inj_arm/inj_pos/inj_mask sampled at accept).
module burst_cw_serializer
    import burst_code_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    burst_cw_serializer_if.slave  bus
);

    state_t state;
    state_t state_next;
    cnt_t   cnt;
    cnt_t   cnt_next;
    cw_t    hold;
    logic   load;
    logic   frame_end;
    logic   last;
    logic   flip;

    logic   cw_ready;
    logic   ser_valid;
    logic   ser_bit;
    logic   ser_sof;
    logic   ser_eof;

`ifdef BURST_INJECT_EN
    logic   armed;
    cnt_t   inj_pos;
    burst_t inj_mask;
    logic   flip_raw;

    burst_injector u_injector (
        .cnt  (cnt),
        .pos  (inj_pos),
        .mask (inj_mask),
        .flip (flip_raw)
    );

    assign flip = armed & flip_raw;

    // Injection settings are captured with the codeword; the arm drops after eof
    always_ff @(posedge clk) begin
        if (rst) begin
            armed <= 1'b0;
        end else if (load) begin
            armed    <= bus.inj_arm;
            inj_pos  <= bus.inj_pos;
            inj_mask <= bus.inj_mask;
        end else if (frame_end) begin
            armed <= 1'b0;
        end
    end
`else
    assign flip = 1'b0;
`endif

    // State and bit-counter register; rst takes priority over any accept
    // NOTE: registers are updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Codeword holding register, written only on accept
    // NOTE: hold is pure datapath behind the state gating, so it carries no reset.
    always_ff @(posedge clk) begin
        if (load) begin
            hold <= bus.cw;
        end
    end

    // Next-state, counter and output decode
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        load       = 1'b0;
        frame_end  = 1'b0;
        cw_ready   = 1'b0;
        ser_valid  = 1'b0;
        ser_bit    = 1'b0;
        ser_sof    = 1'b0;
        ser_eof    = 1'b0;
        last       = (cnt == LAST_BIT);

        unique case (state)
            IDLE: begin
                cw_ready = 1'b1;
                if (bus.cw_valid) begin
                    load       = 1'b1;
                    cnt_next   = '0;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                ser_valid = 1'b1;
                ser_bit   = hold[cnt] ^ flip;
                ser_sof   = (cnt == '0);
                ser_eof   = last;
                cw_ready  = bus.ser_ready & last;
                if (bus.ser_ready) begin
                    if (last) begin
                        frame_end = 1'b1;
                        cnt_next  = '0;
                        if (bus.cw_valid) begin
                            load = 1'b1;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        cnt_next = cnt + cnt_t'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.cw_ready  = cw_ready;
    assign bus.ser_valid = ser_valid;
    assign bus.ser_bit   = ser_bit;
    assign bus.ser_sof   = ser_sof;
    assign bus.ser_eof   = ser_eof;

endmodule

// File: tb/tb_burst_cw_serializer.sv
// Self-checking bench for burst_cw_serializer. A frame-level model (current
// codeword plus beat index) predicts every output each cycle; directed
// scenarios pin the model with hand-computed frames. When BURST_INJECT_EN is
// defined the injector is exercised as well.
module tb_burst_cw_serializer;
    import burst_code_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    burst_cw_serializer_if bus ();

    burst_cw_serializer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int tests = 0;
    int fails = 0;

    // Model state: frame being sent and index of the beat currently offered
    bit     m_busy  = 1'b0;
    cw_t    m_frame = '0;
    int     m_idx   = 0;
    bit     m_armed = 1'b0;
    int     m_pos   = 0;
    burst_t m_mask  = '0;

    // Observations of the DUT stream, cleared per scenario
    cw_t obs_cap = '0;
    int  obs_pos = 0;
    int  beats = 0;
    int  sof_cnt = 0;
    int  eof_cnt = 0;
    int  run = 0;
    int  max_run = 0;
    int  ready_pulses = 0;
    int  ready_early = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic cw_t rand_cw();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[40:0];
    endfunction

    // Per-cycle compare, observation and model update on the falling edge
    always @(negedge clk) begin
        logic e_bit;
        logic e_ready;
        int   off;

        e_bit = 1'b0;
        if (m_busy) begin
            e_bit = m_frame[m_idx];
            off   = m_idx - m_pos;
            if (m_armed && off >= 0 && off < BURST_LEN) e_bit = e_bit ^ m_mask[off];
        end
        e_ready = !m_busy || (bus.ser_ready && m_idx == N - 1);

        check("ser_valid", bus.ser_valid, m_busy);
        check("ser_bit",   bus.ser_bit,   e_bit);
        check("ser_sof",   bus.ser_sof,   m_busy && m_idx == 0);
        check("ser_eof",   bus.ser_eof,   m_busy && m_idx == N - 1);
        check("cw_ready",  bus.cw_ready,  e_ready);

        if (bus.ser_valid) run++; else run = 0;
        if (run > max_run) max_run = run;
        if (bus.ser_valid && bus.cw_ready) begin
            ready_pulses++;
            if (!bus.ser_eof) ready_early++;
        end
        if (bus.ser_valid && bus.ser_ready) begin
            if (bus.ser_sof) begin
                obs_pos = 0;
                sof_cnt++;
            end
            if (obs_pos < N) obs_cap[obs_pos] = bus.ser_bit;
            obs_pos++;
            beats++;
            if (bus.ser_eof) eof_cnt++;
        end

        if (rst) begin
            m_busy  = 1'b0;
            m_armed = 1'b0;
            m_idx   = 0;
        end else begin
            if (m_busy && bus.ser_ready) begin
                if (m_idx == N - 1) begin
                    m_busy  = 1'b0;
                    m_armed = 1'b0;
                end else begin
                    m_idx++;
                end
            end
            if (bus.cw_valid && e_ready) begin
                m_frame = bus.cw;
                m_idx   = 0;
                m_busy  = 1'b1;
`ifdef BURST_INJECT_EN
                m_armed = bus.inj_arm;
                m_pos   = int'(bus.inj_pos);
                m_mask  = bus.inj_mask;
`endif
            end
        end
    end

    task automatic clear_obs();
        obs_cap = '0;
        obs_pos = 0;
        beats = 0;
        sof_cnt = 0;
        eof_cnt = 0;
        max_run = 0;
        ready_pulses = 0;
        ready_early = 0;
    endtask

    // Offer v until accepted; optionally keep cw_valid high afterwards
    task automatic send(input cw_t v, input bit keep);
        int n;
        bit acc;
        n = 0;
        acc = 1'b0;
        bus.cw_valid = 1'b1;
        bus.cw = v;
        while (!acc && n < 500) begin
            @(negedge clk);
            acc = bus.cw_ready && !rst;
            @(posedge clk);
            #1;
            n++;
        end
        check("accept_reached", acc, 1'b1);
        if (!keep) begin
            bus.cw_valid = 1'b0;
            bus.cw = rand_cw();
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (bus.ser_valid && n < 500);
        check("idle_reached", bus.ser_valid, 1'b0);
    endtask

    task automatic wait_beat(input int idx);
        int n;
        n = 0;
        while (!(m_busy && m_idx == idx) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("beat_reached", n < 500, 1'b1);
    endtask

`ifdef BURST_INJECT_EN
    task automatic set_inj(input bit arm, input int pos, input burst_t mask);
        bus.inj_arm  = arm;
        bus.inj_pos  = cnt_t'(pos);
        bus.inj_mask = mask;
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        cw_t  v;
        cw_t  v2;
        cw_t  e;
        msg_t m;
        logic [0:R-1] p;

        bus.cw_valid  = 1'b0;
        bus.cw        = '0;
        bus.ser_ready = 1'b1;
`ifdef BURST_INJECT_EN
        set_inj(1'b0, 0, '0);
`endif
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ser_valid", bus.ser_valid, 1'b0);
        check("reset_cw_ready",  bus.cw_ready,  1'b1);
        check("reset_ser_bit",   bus.ser_bit,   1'b0);
        rst = 1'b0;

        // Single frame with only bit 0 set
        clear_obs();
        v = '0;
        v[0] = 1'b1;
        send(v, 1'b0);
        check("single_first_valid", bus.ser_valid, 1'b1);
        wait_idle();
        check("single_bit0", obs_cap[0], 1'b1);
        check("single_rest", obs_cap[1:N-1], '0);
        check("single_beats", beats, 41);
        check("single_sof", sof_cnt, 1);
        check("single_eof", eof_cnt, 1);

        // Encoder chain: m = 1 gives parity 001000001, ones at 31, 34, 40
        clear_obs();
        m = 32'h0000_0001;
        p = 9'b001000001;
        v = {m, p};
        e = '0;
        e[31] = 1'b1;
        e[34] = 1'b1;
        e[40] = 1'b1;
        send(v, 1'b0);
        wait_idle();
        check("enc_chain_stream", obs_cap, e);

        // Backpressure: three stalled cycles at beat 10
        clear_obs();
        v = rand_cw();
        send(v, 1'b0);
        wait_beat(10);
        bus.ser_ready = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("stall_held_idx", m_idx, 10);
        bus.ser_ready = 1'b1;
        wait_idle();
        check("stall_beats", beats, 41);
        check("stall_stream", obs_cap, v);
        check("stall_eof", eof_cnt, 1);

        // Back-to-back frames with cw_valid held
        clear_obs();
        v  = rand_cw();
        v2 = rand_cw();
        send(v, 1'b1);
        send(v2, 1'b0);
        wait_idle();
        check("b2b_run", max_run, 82);
        check("b2b_beats", beats, 82);
        check("b2b_ready_pulses", ready_pulses, 2);
        check("b2b_ready_early", ready_early, 0);
        check("b2b_sof", sof_cnt, 2);
        check("b2b_stream2", obs_cap, v2);

        // Reset at beat 20 discards the frame
        clear_obs();
        v = rand_cw();
        send(v, 1'b0);
        wait_beat(20);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_valid", bus.ser_valid, 1'b0);
        check("rst_mid_ready", bus.cw_ready, 1'b1);
        rst = 1'b0;
        check("rst_mid_no_eof", eof_cnt, 0);
        clear_obs();
        v2 = rand_cw();
        send(v2, 1'b0);
        wait_idle();
        check("rst_after_stream", obs_cap, v2);
        check("rst_after_sof", sof_cnt, 1);
        check("rst_after_beats", beats, 41);

`ifdef BURST_INJECT_EN
        // Burst at 7 with mask 101 flips beats 7 and 9 only
        clear_obs();
        v = rand_cw();
        set_inj(1'b1, 7, 3'b101);
        send(v, 1'b0);
        set_inj(1'b0, 0, '0);
        wait_idle();
        e = v;
        e[7] = ~e[7];
        e[9] = ~e[9];
        check("inj_7_101", obs_cap, e);
        clear_obs();
        send(v, 1'b0);
        wait_idle();
        check("inj_next_clean", obs_cap, v);

        // Burst clipped at the last bit
        clear_obs();
        set_inj(1'b1, 40, 3'b111);
        send(v, 1'b0);
        set_inj(1'b0, 0, '0);
        wait_idle();
        e = v;
        e[40] = ~e[40];
        check("inj_clip", obs_cap, e);

        // Position beyond the codeword injects nothing
        clear_obs();
        set_inj(1'b1, 45, 3'b111);
        send(v, 1'b0);
        set_inj(1'b0, 0, '0);
        wait_idle();
        check("inj_pos_out", obs_cap, v);
`endif

        // Randomized traffic with backpressure, gaps and rare resets
        for (int i = 0; i < 2500; i++) begin
            @(posedge clk);
            #1;
            rst           = ($urandom_range(0, 599) == 0);
            bus.cw_valid  = ($urandom_range(0, 3) != 0);
            bus.cw        = rand_cw();
            bus.ser_ready = ($urandom_range(0, 3) != 0);
`ifdef BURST_INJECT_EN
            set_inj($urandom_range(0, 2) == 0, int'($urandom_range(0, 47)), burst_t'($urandom_range(0, 7)));
`endif
        end
        rst = 1'b0;
        bus.cw_valid = 1'b0;
        bus.ser_ready = 1'b1;
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/burst_cw_serializer.md
Name: burst_cw_serializer

Overview:
- Sits directly downstream of the (41,32) burst-3 encoder (`encoder`).
- Accepts one 41-bit codeword per valid/ready handshake and shifts it onto a 1-bit channel, c[0] first.
- Provides start/end-of-frame flags and honours downstream backpressure.
- A compile-time burst-error injector models channel bursts of length ≤3 so that the (41,32) `decoder` correction path can be exercised end to end.

Parameters:
- N, 41, codeword length in bits
- CNT_W, 6, bit-counter width; must satisfy 2^CNT_W ≥ N

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- cw_valid  in  1  upstream codeword valid
- cw_ready  out  1  block can accept a codeword this cycle
- cw  in  N  codeword, index [0:N-1] = {m[0:31], p[0:8]}
- ser_valid  out  1  ser_bit is a valid channel bit
- ser_ready  in  1  downstream accepts ser_bit this cycle
- ser_bit  out  1  current channel bit
- ser_sof  out  1  ser_bit is codeword bit 0
- ser_eof  out  1  ser_bit is codeword bit N-1
- inj_arm  in  1  (BURST_INJECT_EN only) arm injection for next accepted codeword
- inj_pos  in  CNT_W  (BURST_INJECT_EN only) first corrupted bit index
- inj_mask  in  3  (BURST_INJECT_EN only) burst pattern; bit0 → pos, bit1 → pos+1, bit2 → pos+2

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst); the polarity and synchronicity are fixed.
- Reset values: ser_valid=0, ser_sof=0, ser_eof=0, ser_bit=0, cw_ready=1, bit counter=0, state=IDLE, injection disarmed.
- State IDLE:
  - cw_ready=1 and ser_valid=0.
  - On cw_valid&cw_ready: load holding register with cw, set counter=0, go to SHIFT.
  - ser_valid rises the next cycle (latency 1 clock from accept to first bit).
- State SHIFT:
  - ser_valid=1 and ser_bit=hold[counter].
  - ser_sof=(counter==0); ser_eof=(counter==N-1).
  - A beat completes when ser_valid&ser_ready; counter increments only on a completed beat.
  - While ser_ready=0, ser_bit, ser_sof and ser_eof hold stable.
- cw_ready in SHIFT = ser_ready & (counter==N-1); the last beat and the next accept may coincide.
  - If the last beat completes and cw_valid=1 in the same cycle: load the new codeword, counter=0, stay in SHIFT.
  - The result is back-to-back frames with no idle gap: 41 beats per frame at full rate.
  - If the last beat completes and cw_valid=0: go to IDLE.
- cw is sampled only at accept; later changes on cw are ignored.
- Counter never exceeds N-1; no wrap through unused codes 41..63.
- rst asserted mid-frame: the frame is discarded, all outputs take reset values on the next edge, and no partial eof is issued.
- Simultaneous rst and cw_valid: rst wins and the codeword is not accepted.

Optional Feature:
- Macro: BURST_INJECT_EN.
- Defined:
  - inj_arm, inj_pos and inj_mask are sampled at the codeword accept cycle.
  - If armed, ser_bit = hold[counter] ^ inj_mask[counter-inj_pos] for counter in pos..pos+2 (clipped at N-1).
  - Arm clears after that frame's eof.
  - inj_pos ≥ N injects nothing.
- Not defined:
  - inj_* ports are absent.
  - ser_bit = hold[counter] exactly.
  - No injection logic is synthesised.

Decomposition:
- Shared package burst_code_pkg holds:
  - localparams N=41, K=32, R=9, BURST_LEN=3
  - typedef cw_t (logic [0:N-1])
  - typedef msg_t (logic [0:K-1])
  - state enum {IDLE, SHIFT}
- One natural sub-module: burst_injector (combinational mask generator from inj_pos, inj_mask and counter), instantiated only under BURST_INJECT_EN.

Test Plan:
- Single frame, ser_ready=1: cw with only bit 0 set → beat 0 ser_bit=1 with ser_sof=1; beats 1..40 ser_bit=0; ser_eof on beat 40; then IDLE with ser_valid=0.
- Encoder chain, m=32'h0000_0001 → cw p=9'b001000001 → ser_bit=1 exactly at beats 31, 34 and 40.
- Backpressure, ser_ready=0 for 3 cycles at beat 10 → ser_bit and counter hold; frame still ends with exactly 41 completed beats.
- Back-to-back, two codewords with cw_valid held → 82 consecutive valid beats; cw_ready pulses on beat 40 only; second ser_sof immediately follows first ser_eof.
- Reset at beat 20 → next cycle ser_valid=0 and cw_ready=1; the following frame starts at sof with fresh data.
- BURST_INJECT_EN, inj_arm=1, inj_pos=7, inj_mask=3'b101 → beats 7 and 9 inverted; the decoder output equals the original m; the next frame is uncorrupted.
